// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial sequence detector.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out on
// dout one bit per clock, holding IDLE_LEVEL between frames, with an optional
// GAP_CYCLES idle gap after each frame.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit to each frame.
module bit_serializer #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic        IDLE_LEVEL = 1'b1,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH + 2);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
`ifdef SER_PARITY_EN
   localparam int unsigned FRAME_LEN = WIDTH + 1;
   localparam logic [CW-1:0] PAR_IDX = CW'(WIDTH - 1);
`else
   localparam int unsigned FRAME_LEN = WIDTH;
`endif
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
   localparam int unsigned   GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [GW-1:0] GAP_END  = GW'(GAP_LAST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [GW-1:0]    gcnt, gcnt_n;
   logic             dout_n, dout_valid_n, done_n;
   logic             accept;
`ifdef SER_PARITY_EN
   logic             par, par_n;
`endif

   // Ready comes only from state and counter; the last-bit window opens only without a gap.
   assign load_ready = (state == IDLE) ||
                       ((GAP_CYCLES == 0) && (state == SHIFT) && (cnt == LAST_IDX));
   assign accept = load_valid && load_ready;

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         gcnt       <= '0;
         dout       <= IDLE_LEVEL;
         dout_valid <= 1'b0;
         done       <= 1'b0;
`ifdef SER_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         cnt        <= cnt_n;
         gcnt       <= gcnt_n;
         dout       <= dout_n;
         dout_valid <= dout_valid_n;
         done       <= done_n;
`ifdef SER_PARITY_EN
         par        <= par_n;
`endif
      end
   end

   // Next-state and next-output decode. On accept the first bit is registered
   // straight from data_in, and shreg keeps the remaining bits head-aligned.
   always_comb begin
      state_n      = state;
      shreg_n      = shreg;
      cnt_n        = cnt;
      gcnt_n       = gcnt;
      dout_n       = IDLE_LEVEL;
      dout_valid_n = 1'b0;
      done_n       = 1'b0;
`ifdef SER_PARITY_EN
      par_n        = par;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               state_n      = SHIFT;
               cnt_n        = '0;
               dout_n       = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
               dout_valid_n = 1'b1;
               shreg_n      = MSB_FIRST ? {data_in[WIDTH-2:0], 1'b0} : {1'b0, data_in[WIDTH-1:1]};
`ifdef SER_PARITY_EN
               par_n        = ^data_in;
`endif
            end
         end
         SHIFT: begin
            if (cnt == LAST_IDX) begin
               cnt_n = '0;
               if (accept) begin
                  state_n      = SHIFT;
                  dout_n       = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
                  dout_valid_n = 1'b1;
                  shreg_n      = MSB_FIRST ? {data_in[WIDTH-2:0], 1'b0} : {1'b0, data_in[WIDTH-1:1]};
`ifdef SER_PARITY_EN
                  par_n        = ^data_in;
`endif
               end else if (GAP_CYCLES > 0) begin
                  state_n = GAP;
                  gcnt_n  = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n        = cnt + CW'(1);
               dout_valid_n = 1'b1;
               done_n       = ((cnt + CW'(1)) == LAST_IDX);
               dout_n       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
`ifdef SER_PARITY_EN
               if (cnt == PAR_IDX) dout_n = par;
`endif
               shreg_n      = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            end
         end
         GAP: begin
            if (gcnt == GAP_END) begin
               state_n = IDLE;
               gcnt_n  = '0;
            end else begin
               gcnt_n = gcnt + GW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed bench with a per-instance expected-bit scoreboard.
// u0 = defaults (MSB first), u1 = LSB first, u2 = GAP_CYCLES=2.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   typedef struct packed {
      logic b;
      logic d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data = 8'h00;
   logic       v01 = 1'b0;
   logic       v2 = 1'b0;
   logic       mon_en = 1'b0;

   logic rdy0, dout0, dv0, done0;
   logic rdy1, dout1, dv1, done1;
   logic rdy2, dout2, dv2, done2;

   int vectors = 0;
   int errors  = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8)) u0 (
      .clk(clk), .rst(rst), .data_in(data), .load_valid(v01),
      .load_ready(rdy0), .dout(dout0), .dout_valid(dv0), .done(done0));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
      .clk(clk), .rst(rst), .data_in(data), .load_valid(v01),
      .load_ready(rdy1), .dout(dout1), .dout_valid(dv1), .done(done1));

   bit_serializer #(.WIDTH(8), .GAP_CYCLES(2)) u2 (
      .clk(clk), .rst(rst), .data_in(data), .load_valid(v2),
      .load_ready(rdy2), .dout(dout2), .dout_valid(dv2), .done(done2));

   task automatic chk(input string tag, input logic obs, input logic expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
      if (i >= 8) return ^w;
      return msb ? w[7-i] : w[i];
   endfunction

   task automatic push01(input logic [7:0] w);
      for (int i = 0; i < FL; i++) begin
         q0.push_back('{b: exp_bit(w, i, 1'b1), d: (i == FL - 1)});
         q1.push_back('{b: exp_bit(w, i, 1'b0), d: (i == FL - 1)});
      end
   endtask

   task automatic push2(input logic [7:0] w);
      for (int i = 0; i < FL; i++)
         q2.push_back('{b: exp_bit(w, i, 1'b1), d: (i == FL - 1)});
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Stream checker: every valid bit must match the scoreboard head; idle cycles show IDLE_LEVEL.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (dv0) begin
            if (q0.size() == 0) chk("u0_extra_bit", dv0, 1'b0);
            else begin
               e = q0.pop_front();
               chk("u0_bit", dout0, e.b);
               chk("u0_done", done0, e.d);
            end
         end else begin
            chk("u0_idle", dout0, 1'b1);
            chk("u0_idle_done", done0, 1'b0);
         end
         if (dv1) begin
            if (q1.size() == 0) chk("u1_extra_bit", dv1, 1'b0);
            else begin
               e = q1.pop_front();
               chk("u1_bit", dout1, e.b);
               chk("u1_done", done1, e.d);
            end
         end else begin
            chk("u1_idle", dout1, 1'b1);
            chk("u1_idle_done", done1, 1'b0);
         end
         if (dv2) begin
            if (q2.size() == 0) chk("u2_extra_bit", dv2, 1'b0);
            else begin
               e = q2.pop_front();
               chk("u2_bit", dout2, e.b);
               chk("u2_done", done2, e.d);
            end
         end else begin
            chk("u2_idle", dout2, 1'b1);
            chk("u2_idle_done", done2, 1'b0);
         end
      end
   end

   initial begin
      // Reset for two cycles, then idle outputs
      tick(2);
      rst = 1'b0;
      chk("rst_dout", dout0, 1'b1);
      chk("rst_dv", dv0, 1'b0);
      chk("rst_done", done0, 1'b0);
      chk("rst_ready0", rdy0, 1'b1);
      chk("rst_ready1", rdy1, 1'b1);
      chk("rst_ready2", rdy2, 1'b1);
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("idle_ready", rdy0, 1'b1);
      end

      // Single frames: 8'hB2 then 8'h07, with ignored loads and data changes mid-frame
      for (int f = 0; f < 2; f++) begin
         data = (f == 0) ? 8'hB2 : 8'h07;
         v01  = 1'b1;
         chk("single_ready", rdy0, 1'b1);
         push01(data);
         tick(1);
         v01  = 1'b0;
         data = 8'h55;
         tick(2);
         chk("mid_ready", rdy0, 1'b0);
         v01  = 1'b1;
         data = 8'hFF;
         tick(1);
         v01  = 1'b0;
         tick(FL - 3);
         chk("after_frame_dv", dv0, 1'b0);
         chk("after_frame_ready", rdy0, 1'b1);
         tick(2);
      end

      // Back-to-back: 8'hB2 then 8'h0F with load_valid held
      data = 8'hB2;
      v01  = 1'b1;
      push01(data);
      tick(1);
      data = 8'h0F;
      for (int i = 1; i < FL; i++) begin
         chk("b2b_dv_a", dv0, 1'b1);
         chk("b2b_ready_a", rdy0, 1'b0);
         tick(1);
      end
      chk("b2b_last_ready", rdy0, 1'b1);
      chk("b2b_last_ready_lsb", rdy1, 1'b1);
      push01(data);
      tick(1);
      v01 = 1'b0;
      for (int i = 0; i < FL; i++) begin
         chk("b2b_dv_b", dv0, 1'b1);
         tick(1);
      end
      chk("b2b_end_dv", dv0, 1'b0);
      tick(2);

      // Gap instance: load held, two forced idle cycles, accept 3 cycles after the last bit
      data = 8'hB2;
      v2   = 1'b1;
      push2(data);
      tick(1);
      tick(FL - 1);
      chk("gap_last_ready", rdy2, 1'b0);
      chk("gap_last_dv", dv2, 1'b1);
      tick(1);
      chk("gap1_ready", rdy2, 1'b0);
      chk("gap1_dv", dv2, 1'b0);
      tick(1);
      chk("gap2_ready", rdy2, 1'b0);
      chk("gap2_dout", dout2, 1'b1);
      data = 8'h0F;
      tick(1);
      chk("gap_idle_ready", rdy2, 1'b1);
      chk("gap_idle_dv", dv2, 1'b0);
      push2(data);
      tick(1);
      v2 = 1'b0;
      chk("gap_frame2_dv", dv2, 1'b1);
      tick(FL + 3);

      // Abort: reset after the 3rd bit of 8'hB2
      data = 8'hB2;
      v01  = 1'b1;
      push01(data);
      tick(1);
      v01 = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      q0.delete();
      q1.delete();
      rst = 1'b0;
      chk("abort_dout", dout0, 1'b1);
      chk("abort_dv", dv0, 1'b0);
      chk("abort_done", done0, 1'b0);
      chk("abort_ready", rdy0, 1'b1);
      tick(FL + 2);

      // Nothing expected may remain outstanding
      mon_en = 1'b0;
      vectors++;
      assert (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) else begin
         errors++;
         $error("FAIL queues_empty: observed %0d/%0d/%0d pending expected 0", q0.size(), q1.size(), q2.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
